// File: rtl/elbeth_fetch_unit_if.sv
// Instruction-memory port of the Elbeth fetch unit.
// The memory answers in the same cycle as the request (zero-latency handshake).
interface elbeth_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic        error;

  modport master (output req, output addr, input ready, input rdata, input error);
  modport slave  (input req, input addr, output ready, output rdata, output error);
endinterface

// File: rtl/elbeth_fetch_unit.sv
// Elbeth instruction fetch unit.
// Issues zero-latency fetches at pc and presents the result to IF/ID.
// A stalled instruction is parked in a one-entry hold buffer. Fetch faults
// are shown once as an exception slot, after which the unit halts until it
// is redirected.
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  elbeth_fetch_unit_if.master        imem,
  input  logic                       ex_branch_taken,
  input  logic [31:0]                ex_branch_target,
  input  logic                       exc_redirect,
  input  logic [31:0]                exc_vector,
  input  logic                       ctrl_stall,
  output logic [31:0]                if_instruction,
  output logic [31:0]                if_pc,
  output logic                       if_except,
  output logic [3:0]                 if_except_src,
  output logic                       if_stall_req
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_EXC_OUT,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        pc_aligned;
  logic [31:0] pc_plus4;

  // Trap redirects beat branches; either one squashes whatever is in flight.
  assign redirect        = exc_redirect | ex_branch_taken;
  assign redirect_target = exc_redirect ? exc_vector : ex_branch_target;
  assign pc_aligned      = (pc_q[1:0] == 2'b00);
  // Plain 32-bit add, so 32'hFFFF_FFFC rolls over to 0.
  assign pc_plus4        = pc_q + 32'd4;
  assign imem.addr       = pc_q;

  // Next-state, next-pc and IF/ID slot contents.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_insn_d    = hold_insn_q;
    hold_pc_d      = hold_pc_q;
    imem.req       = 1'b0;
    if_instruction = NOP_INSN;
    if_pc          = 32'h0;
    if_except      = 1'b0;
    if_except_src  = 4'd0;
    if_stall_req   = 1'b0;

    if (redirect) begin
      // Slot stays a bubble; any response, held instruction or fault is dropped.
      pc_d        = redirect_target;
      state_d     = S_FETCH;
      hold_insn_d = 32'h0;
      hold_pc_d   = 32'h0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (!pc_aligned) begin
            state_d = S_EXC_OUT;
          end else begin
            imem.req = 1'b1;
            if (imem.ready && imem.error) begin
              state_d = S_EXC_OUT;
            end else if (imem.ready) begin
              if_instruction = imem.rdata;
              if_pc          = pc_q;
              if (ctrl_stall) begin
                hold_insn_d = imem.rdata;
                hold_pc_d   = pc_q;
                state_d     = S_HOLD;
              end else begin
                pc_d = pc_plus4;
              end
            end else begin
              if_stall_req = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if_instruction = hold_insn_q;
          if_pc          = hold_pc_q;
          if (!ctrl_stall) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end
        end
        S_EXC_OUT: begin
          // Access faults only come from aligned fetches, so alignment names the cause.
          if_pc         = pc_q;
          if_except     = 1'b1;
          if_except_src = pc_aligned ? 4'd1 : 4'd0;
          if (!ctrl_stall) begin
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end

    // While reset is held the slot and the request are quiet.
    if (!rst_n) begin
      imem.req       = 1'b0;
      if_instruction = NOP_INSN;
      if_pc          = 32'h0;
      if_except      = 1'b0;
      if_except_src  = 4'd0;
      if_stall_req   = 1'b0;
    end
  end

  // State, pc and hold buffer registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      // NOTE: the hold buffer is two ordinary registers, not a RAM, so it is reset with the rest.
      hold_insn_q <= 32'h0;
      hold_pc_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_insn_q <= hold_insn_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// Self-checking bench for elbeth_fetch_unit: directed vector table,
// hand-written corner sequences, then random stimulus against a reference model.
module tb_elbeth_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        ready, err, stall, br, exr;
  logic [31:0] brt, exv;
  logic [31:0] if_instruction, if_pc;
  logic        if_except, if_stall_req;
  logic [3:0]  if_except_src;

  int n_checks = 0;
  int n_pass   = 0;

  elbeth_fetch_unit_if imem_if ();

  // Deterministic memory contents: each word is a hash of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  assign imem_if.ready = ready;
  assign imem_if.error = err;
  assign imem_if.rdata = mem_word(imem_if.addr);

  elbeth_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem_if),
    .ex_branch_taken  (br),
    .ex_branch_target (brt),
    .exc_redirect     (exr),
    .exc_vector       (exv),
    .ctrl_stall       (stall),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_except        (if_except),
    .if_except_src    (if_except_src),
    .if_stall_req     (if_stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {req, addr, instruction, pc, except, src, stall_req}
  function automatic logic [102:0] exp_v(input logic rq, input logic [31:0] ad,
                                         input logic [31:0] ins, input logic [31:0] pc,
                                         input logic ex, input logic [3:0] src, input logic sr);
    return {rq, ad, ins, pc, ex, src, sr};
  endfunction

  function automatic logic [102:0] act_v();
    return {imem_if.req, imem_if.addr, if_instruction, if_pc, if_except, if_except_src, if_stall_req};
  endfunction

  task automatic check(input string name, input logic [102:0] act, input logic [102:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {req,addr,insn,pc,exc,src,stall}=%h required %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic rd, input logic er, input logic st,
                       input logic b, input logic [31:0] bt, input logic x, input logic [31:0] xv);
    rst_n = r; ready = rd; err = er; stall = st; br = b; brt = bt; exr = x; exv = xv;
  endtask

  // One cycle: drive just after the edge, compare on the falling edge.
  task automatic cyc(input string name, input logic r, input logic rd, input logic er,
                     input logic st, input logic b, input logic [31:0] bt, input logic x,
                     input logic [31:0] xv, input logic [102:0] exp);
    @(posedge clk);
    #1;
    drive(r, rd, er, st, b, bt, x, xv);
    @(negedge clk);
    check(name, act_v(), exp);
  endtask

  typedef struct {
    string       name;
    logic        r, rd, er, st, b, x;
    logic [31:0] bt, xv;
    logic [102:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input string nm, input logic r, input logic rd, input logic er,
                              input logic st, input logic b, input logic [31:0] bt,
                              input logic x, input logic [31:0] xv, input logic [102:0] e);
    vec_t v;
    v.name = nm; v.r = r; v.rd = rd; v.er = er; v.st = st;
    v.b = b; v.bt = bt; v.x = x; v.xv = xv; v.exp = e;
    tbl.push_back(v);
  endfunction

  // Reference model: tracks pc plus what the fetch stage currently owes the pipeline.
  logic [31:0] m_pc;
  bit          m_held, m_exc, m_halted;
  logic [3:0]  m_cause;

  task automatic model_cycle(output logic [102:0] e);
    logic        rq  = 1'b0;
    logic [31:0] ad  = m_pc;
    logic [31:0] ins = NOP;
    logic [31:0] ipc = 32'h0;
    logic        ex  = 1'b0;
    logic [3:0]  src = 4'd0;
    logic        sr  = 1'b0;
    if (!rst_n) begin
      ad = RST_PC;
      m_pc = RST_PC; m_held = 0; m_exc = 0; m_halted = 0;
    end else if (exr || br) begin
      m_pc = exr ? exv : brt;
      m_held = 0; m_exc = 0; m_halted = 0;
    end else if (m_halted) begin
      // nothing presented, nothing requested
    end else if (m_exc) begin
      ipc = m_pc; ex = 1'b1; src = m_cause;
      if (!stall) begin m_exc = 0; m_halted = 1; end
    end else if (m_held) begin
      ins = mem_word(m_pc); ipc = m_pc;
      if (!stall) begin m_held = 0; m_pc = m_pc + 32'd4; end
    end else if (m_pc % 4 != 0) begin
      m_exc = 1; m_cause = 4'd0;
    end else begin
      rq = 1'b1;
      if (ready && err) begin
        m_exc = 1; m_cause = 4'd1;
      end else if (ready) begin
        ins = mem_word(m_pc); ipc = m_pc;
        if (stall) m_held = 1;
        else m_pc = m_pc + 32'd4;
      end else begin
        sr = 1'b1;
      end
    end
    e = exp_v(rq, ad, ins, ipc, ex, src, sr);
  endtask

  initial begin
    logic [102:0] e;
    drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

    //   name          rst rdy err stl br  brt            exr exv
    row("reset",        0,  0,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h0, NOP, 32'h0, 0, 0, 0));
    row("seq_0",        1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h0, mem_word(32'h0), 32'h0, 0, 0, 0));
    row("seq_4",        1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h4, mem_word(32'h4), 32'h4, 0, 0, 0));
    row("stall_8",      1,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h8, mem_word(32'h8), 32'h8, 0, 0, 0));
    row("hold_8a",      1,  0,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h8, mem_word(32'h8), 32'h8, 0, 0, 0));
    row("hold_8b",      1,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h8, mem_word(32'h8), 32'h8, 0, 0, 0));
    row("hold_8_rel",   1,  0,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h8, mem_word(32'h8), 32'h8, 0, 0, 0));
    row("seq_12",       1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'hC, mem_word(32'hC), 32'hC, 0, 0, 0));
    row("wait_16a",     1,  0,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h10, NOP, 32'h0, 0, 0, 1));
    row("wait_16b",     1,  0,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h10, NOP, 32'h0, 0, 0, 1));
    row("seq_16",       1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h10, mem_word(32'h10), 32'h10, 0, 0, 0));
    row("redir_prio",   1,  1,  0,  0,  1, 32'h100,       1, 32'h80, exp_v(0, 32'h14, NOP, 32'h0, 0, 0, 0));
    row("vec_80",       1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h80, mem_word(32'h80), 32'h80, 0, 0, 0));
    row("br_misalign",  1,  1,  0,  0,  1, 32'h102,       0, 32'h0, exp_v(0, 32'h84, NOP, 32'h0, 0, 0, 0));
    row("misalign_req", 1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h102, NOP, 32'h0, 0, 0, 0));
    row("misalign_exc", 1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h102, NOP, 32'h102, 1, 0, 0));
    row("halt_a",       1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h102, NOP, 32'h0, 0, 0, 0));
    row("resume_40",    1,  1,  0,  0,  0, 32'h0,         1, 32'h40, exp_v(0, 32'h102, NOP, 32'h0, 0, 0, 0));
    row("err_40",       1,  1,  1,  1,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h40, NOP, 32'h0, 0, 0, 0));
    row("fault_a",      1,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h40, NOP, 32'h40, 1, 1, 0));
    row("fault_b",      1,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h40, NOP, 32'h40, 1, 1, 0));
    row("fault_cons",   1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h40, NOP, 32'h40, 1, 1, 0));
    row("halt_b",       1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(0, 32'h40, NOP, 32'h0, 0, 0, 0));
    row("br_200",       1,  1,  0,  0,  1, 32'h200,       0, 32'h0, exp_v(0, 32'h40, NOP, 32'h0, 0, 0, 0));
    row("stall_200",    1,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h200, mem_word(32'h200), 32'h200, 0, 0, 0));
    row("rst_in_hold",  0,  1,  0,  1,  0, 32'h0,         0, 32'h0, exp_v(0, RST_PC, NOP, 32'h0, 0, 0, 0));
    row("after_rst",    1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, RST_PC, mem_word(RST_PC), RST_PC, 0, 0, 0));
    row("br_wrap",      1,  1,  0,  0,  1, 32'hFFFF_FFFC, 0, 32'h0, exp_v(0, 32'h4, NOP, 32'h0, 0, 0, 0));
    row("wrap_top",     1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0, 0));
    row("wrap_zero",    1,  1,  0,  0,  0, 32'h0,         0, 32'h0, exp_v(1, 32'h0, mem_word(32'h0), 32'h0, 0, 0, 0));

    foreach (tbl[i])
      cyc(tbl[i].name, tbl[i].r, tbl[i].rd, tbl[i].er, tbl[i].st, tbl[i].b, tbl[i].bt,
          tbl[i].x, tbl[i].xv, tbl[i].exp);

    // Branch alone (no trap redirect) wins over a ready response at pc=4.
    cyc("br_only",    1, 1, 0, 0, 1, 32'h100, 0, 32'h0, exp_v(0, 32'h4, NOP, 32'h0, 0, 0, 0));
    cyc("stall_100",  1, 1, 0, 1, 0, 32'h0,   0, 32'h0, exp_v(1, 32'h100, mem_word(32'h100), 32'h100, 0, 0, 0));
    // Redirect while holding: the held instruction is squashed.
    cyc("br_in_hold", 1, 1, 0, 1, 1, 32'h300, 0, 32'h0, exp_v(0, 32'h100, NOP, 32'h0, 0, 0, 0));
    cyc("after_hold", 1, 1, 0, 0, 0, 32'h0,   0, 32'h0, exp_v(1, 32'h300, mem_word(32'h300), 32'h300, 0, 0, 0));

    // Random traffic against the reference model, starting from a reset cycle.
    m_pc = RST_PC; m_held = 0; m_exc = 0; m_halted = 0; m_cause = 4'd0;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] tgt;
      @(posedge clk);
      #1;
      case ($urandom_range(0, 9))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF8;
        default: tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      drive((n == 0) ? 1'b0 : ($urandom_range(0, 99) >= 1),
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 6,
            tgt,
            $urandom_range(0, 99) < 6,
            {24'h0, 6'($urandom_range(0, 63)), 2'b00});
      @(negedge clk);
      model_cycle(e);
      check($sformatf("rand_%0d", n), act_v(), e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
